// File: rtl/clock_div_monitor.sv
// clock_div_monitor: receive-side checker for a slow divided clock.
//   Synchronises div_clock_in into the system clock domain, emits a one-cycle
//   tick per edge, measures each half-period in system clocks and reports lock
//   once LOCK_COUNT consecutive measurements fall within EXPECTED +/- TOLERANCE.
//   Optional feature macro: CLOCK_DIV_MONITOR_ERRCNT_EN enables err_count.
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-high reset
//   div_clock_in  asynchronous slow clock under test
//   edge_tick     1-cycle pulse per detected edge (either polarity)
//   half_period   last measured half-period in clocks
//   period_valid  1-cycle pulse when half_period is updated
//   locked        rate verified within tolerance
//   timeout       no edge for TIMEOUT_CYCLES clocks; held until next edge
//   err_count     saturating count of rejected measurements and losses
module clock_div_monitor #(
    parameter int unsigned BIT_COUNT      = 17,
    parameter int unsigned EXPECTED       = 100001,
    parameter int unsigned TOLERANCE      = 4,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 131071
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 div_clock_in,
    output logic                 edge_tick,
    output logic [BIT_COUNT-1:0] half_period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 timeout,
    output logic [7:0]           err_count
);

    localparam int unsigned CW     = BIT_COUNT;
    localparam int unsigned HW     = BIT_COUNT + 1;
    localparam int unsigned GW     = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int unsigned LO_INT = (EXPECTED > TOLERANCE) ? (EXPECTED - TOLERANCE) : 0;
    localparam logic [HW-1:0] LO_BOUND = HW'(LO_INT);
    localparam logic [HW-1:0] HI_BOUND = HW'(EXPECTED + TOLERANCE);
    localparam logic [CW-1:0] TMO_VAL  = CW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic            edge_q, edge_d;
    logic [CW-1:0]   hp_cnt_q, hp_cnt_d;
    logic [CW-1:0]   half_period_q, half_period_d;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic            period_valid_q, period_valid_d;
    logic            locked_q, locked_d;
    logic            timeout_q, timeout_d;
    logic            edge_c, good_c, tmo_c;

    // Synchroniser, history flop and edge detect; downstream logic acts on the
    // combinational edge so every output lands in the same cycle as edge_tick.
    always_comb begin
        sync1_d = div_clock_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        edge_c  = sync2_q ^ hist_q;
        edge_d  = edge_c;
    end

    // Half-period counter: restarts at 1 on an edge, saturates at all-ones.
    always_comb begin
        hp_cnt_d = hp_cnt_q;
        if (edge_c) begin
            hp_cnt_d = CW'(1);
        end else if (hp_cnt_q != '1) begin
            hp_cnt_d = hp_cnt_q + CW'(1);
        end
    end

    // Window compare widened by one bit so EXPECTED+TOLERANCE cannot wrap.
    assign good_c = ({1'b0, hp_cnt_q} >= LO_BOUND) && ({1'b0, hp_cnt_q} <= HI_BOUND);
    assign tmo_c  = !edge_c && (hp_cnt_q == TMO_VAL) && (state_q != LOST);

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        good_cnt_d     = good_cnt_q;
        half_period_d  = half_period_q;
        period_valid_d = 1'b0;
        if (edge_c) begin
            case (state_q)
                IDLE, LOST: begin
                    // No predecessor edge, so nothing to measure yet.
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                end
                ACQUIRE: begin
                    period_valid_d = 1'b1;
                    half_period_d  = hp_cnt_q;
                    if (!good_c) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_q == GOOD_MAX) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
                LOCKED: begin
                    period_valid_d = 1'b1;
                    half_period_d  = hp_cnt_q;
                    if (!good_c) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    good_cnt_d = '0;
                end
            endcase
        end else if (tmo_c) begin
            state_d    = LOST;
            good_cnt_d = '0;
        end
        locked_d  = (state_d == LOCKED);
        timeout_d = (state_d == LOST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            hist_q         <= 1'b0;
            edge_q         <= 1'b0;
            hp_cnt_q       <= '0;
            half_period_q  <= '0;
            good_cnt_q     <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            hist_q         <= hist_d;
            edge_q         <= edge_d;
            hp_cnt_q       <= hp_cnt_d;
            half_period_q  <= half_period_d;
            good_cnt_q     <= good_cnt_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign edge_tick    = edge_q;
    assign half_period  = half_period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

`ifdef CLOCK_DIV_MONITOR_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_event_c;

    // Error event: a rejected measurement or entry into LOST.
    always_comb begin
        err_event_c = (edge_c && (state_q == ACQUIRE || state_q == LOCKED) && !good_c)
                      || tmo_c;
        err_cnt_d   = err_cnt_q;
        if (err_event_c && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_clock_div_monitor.sv
// Directed bench for clock_div_monitor with small parameters
// (BIT_COUNT=8 EXPECTED=10 TOLERANCE=1 LOCK_COUNT=3 TIMEOUT_CYCLES=40).
module tb_clock_div_monitor;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst = 1'b1;
    logic       div_in = 1'b0;
    logic       edge_tick;
    logic [7:0] half_period;
    logic       period_valid;
    logic       locked;
    logic       timeout;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    clock_div_monitor #(
        .BIT_COUNT(8),
        .EXPECTED(10),
        .TOLERANCE(1),
        .LOCK_COUNT(3),
        .TIMEOUT_CYCLES(40)
    ) dut (
        .clock(clk),
        .reset(rst),
        .div_clock_in(div_in),
        .edge_tick(edge_tick),
        .half_period(half_period),
        .period_valid(period_valid),
        .locked(locked),
        .timeout(timeout),
        .err_count(err_count)
    );

    // Gated clock so the async reset can be applied with the clock stopped.
    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ecx(input int v);
`ifdef CLOCK_DIV_MONITOR_ERRCNT_EN
        return v;
`else
        return v * 0;
`endif
    endfunction

    function automatic logic [31:0] all_out();
        return {14'd0, edge_tick, period_valid, locked, timeout, half_period, err_count};
    endfunction

    // Entered at the negedge 4 clocks after the previous toggle; toggles the
    // input n clocks after that toggle and checks the resulting edge event,
    // which shows on the third rising clock after the toggle.
    task automatic edge_after(input int n, input string tag, input logic exp_pv,
                              input int exp_hp, input logic exp_lk, input int exp_ec);
        repeat (n - 4) @(negedge clk);
        div_in = ~div_in;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_early"}, 32'(edge_tick), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_tick"}, 32'(edge_tick), 32'd1);
        check({tag, "_pv"}, 32'(period_valid), 32'(exp_pv));
        check({tag, "_hp"}, 32'(half_period), 32'(exp_hp));
        check({tag, "_lock"}, 32'(locked), 32'(exp_lk));
        check({tag, "_tmo"}, 32'(timeout), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'(ecx(exp_ec)));
        @(posedge clk);
        #1;
        check({tag, "_tick_end"}, 32'(edge_tick), 32'd0);
        check({tag, "_pv_end"}, 32'(period_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        // 1: reset held with input toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            div_in = ~div_in;
            @(posedge clk);
            #1;
            check("rst_held", all_out(), 32'd0);
        end
        @(negedge clk);
        div_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 2: nominal rate, lock on the 4th edge
        edge_after(4,  "a", 1'b0, 0,  1'b0, 0);
        edge_after(10, "b", 1'b1, 10, 1'b0, 0);
        edge_after(10, "c", 1'b1, 10, 1'b0, 0);
        edge_after(10, "d", 1'b1, 10, 1'b1, 0);

        // 3: one long half-period drops lock, then relock after 3 good
        edge_after(13, "e", 1'b1, 13, 1'b0, 1);
        edge_after(10, "f", 1'b1, 10, 1'b0, 1);
        edge_after(10, "g", 1'b1, 10, 1'b0, 1);
        edge_after(10, "h", 1'b1, 10, 1'b1, 1);

        // 4: tolerance boundaries
        edge_after(9,  "i", 1'b1, 9,  1'b1, 1);
        edge_after(11, "j", 1'b1, 11, 1'b1, 1);
        edge_after(8,  "k", 1'b1, 8,  1'b0, 2);
        edge_after(10, "l", 1'b1, 10, 1'b0, 2);
        edge_after(11, "m", 1'b1, 11, 1'b0, 2);
        edge_after(12, "n", 1'b1, 12, 1'b0, 3);
        edge_after(9,  "o", 1'b1, 9,  1'b0, 3);
        edge_after(10, "p", 1'b1, 10, 1'b0, 3);
        edge_after(10, "q", 1'b1, 10, 1'b1, 3);

        // 5: frozen input; edge_tick of "q" was on the 3rd rising clock after
        // its toggle, so timeout must rise on the 43rd.
        repeat (38) @(posedge clk);
        #1;
        check("tmo_before", 32'(timeout), 32'd0);
        check("lock_before_tmo", 32'(locked), 32'd1);
        @(posedge clk);
        #1;
        check("tmo_fire", 32'(timeout), 32'd1);
        check("lock_at_tmo", 32'(locked), 32'd0);
        check("err_at_tmo", 32'(err_count), 32'(ecx(4)));
        repeat (5) @(posedge clk);
        #1;
        check("tmo_held", 32'(timeout), 32'd1);
        check("tmo_err_once", 32'(err_count), 32'(ecx(4)));
        @(negedge clk);
        edge_after(4,  "r", 1'b0, 10, 1'b0, 4);
        edge_after(10, "s", 1'b1, 10, 1'b0, 4);
        edge_after(10, "t", 1'b1, 10, 1'b0, 4);
        edge_after(10, "u", 1'b1, 10, 1'b1, 4);

        // 6: async reset while locked with the clock stopped
        clk_en = 1'b0;
        #7;
        rst = 1'b1;
        #1;
        check("async_rst", all_out(), 32'd0);
        #20;
        check("async_rst_hold", all_out(), 32'd0);
        div_in = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clocked", all_out(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_quiet", all_out(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
